// File: rtl/lu_pkg.sv
// ---------------------------------------------------------------------------
// lu_pkg
// Shared types and helpers for the logic-unit arbiter.
//   lu_op_e     : 2-bit operation code (OR, XOR, NOR, XNOR)
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   op2en()     : operation code -> one-hot slice enable {xnor,nor,xor,or}
//   idx_width() : width of an index into an n-entry vector (at least 1 bit)
// Optional feature macro used by the top level: LU_ARB_PERF_EN.
// ---------------------------------------------------------------------------
package lu_pkg;

   typedef enum logic [1:0] {
      LU_OR   = 2'd0,
      LU_XOR  = 2'd1,
      LU_NOR  = 2'd2,
      LU_XNOR = 2'd3
   } lu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   localparam int LU_EN_W = 4;

   // Exactly one slice is enabled; disabled slices drive 0 into the OR4 combiner,
   // so the combiner output equals the enabled slice's result.
   function automatic logic [LU_EN_W-1:0] op2en(input lu_op_e op);
      logic [LU_EN_W-1:0] en;
      unique case (op)
         LU_OR:   en = 4'b0001;
         LU_XOR:  en = 4'b0010;
         LU_NOR:  en = 4'b0100;
         LU_XNOR: en = 4'b1000;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Searches i_req starting at i_ptr
// and moving upward with wrap; the first set bit wins.
// Ports:
//   i_req   [NREQ-1:0]  request vector
//   i_ptr   [IW-1:0]    highest-priority position (0..NREQ-1)
//   o_grant [NREQ-1:0]  one-hot winner (all zero when no request)
//   o_idx   [IW-1:0]    binary index of the winner (0 when no request)
//   o_any               at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import lu_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = idx_width(NREQ)
)
(
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   // w_pos[k] is the requester examined at priority rank k (rank 0 = i_ptr).
   logic [IW:0]   w_sum [NREQ];
   logic [IW-1:0] w_pos [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign w_sum[gi] = {1'b0, i_ptr} + (IW+1)'(gi);
      assign w_pos[gi] = (w_sum[gi] >= (IW+1)'(NREQ)) ?
                         IW'(w_sum[gi] - (IW+1)'(NREQ)) : IW'(w_sum[gi]);
   end

   // Walk ranks from lowest to highest priority so the highest-priority
   // requesting rank is the last one written.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_req[w_pos[k]]) begin
            o_grant           = '0;
            o_grant[w_pos[k]] = 1'b1;
            o_idx             = w_pos[k];
            o_any             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// Shares one W-bit four-function logic unit (OR/XOR/NOR/XNOR slices merged by
// a per-bit OR4 combiner) between NREQ requesters. One transaction in flight:
//   IDLE  : round-robin pick, accept (req_ready one-hot), latch op/operands
//   ISSUE : drive lu_a/lu_b/lu_en for LU_LAT cycles, capture lu_out at the end
//   RESP  : present rsp_valid[grant]/rsp_data until rsp_ready[grant]
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/op/a/b      per-requester request bundle (packed, requester i at slice i)
//   req_ready             one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/data/ready  response to the granted requester
//   lu_a, lu_b, lu_en     logic-unit drive (all zero outside ISSUE)
//   lu_out                OR4 combiner output
//   grant_cnt             per-requester saturating 16-bit grant counters,
//                         present only when LU_ARB_PERF_EN is defined
// ---------------------------------------------------------------------------
module logic_unit_arbiter
   import lu_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int W      = 8,
   parameter int LU_LAT = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [2*NREQ-1:0]   req_op,
   input  logic [W*NREQ-1:0]   req_a,
   input  logic [W*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [W-1:0]        rsp_data,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [W-1:0]        lu_a,
   output logic [W-1:0]        lu_b,
   output logic [LU_EN_W-1:0]  lu_en,
   input  logic [W-1:0]        lu_out
`ifdef LU_ARB_PERF_EN
   ,
   output logic [16*NREQ-1:0]  grant_cnt
`endif
);

   localparam int IW = idx_width(NREQ);
   localparam int CW = (LU_LAT > 1) ? $clog2(LU_LAT) : 1;

   arb_state_e      r_state;
   arb_state_e      w_state_next;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   r_grant_idx;
   lu_op_e          r_op;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_rsp_data;
   logic [CW-1:0]   r_lat_cnt;

   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_win_idx;
   logic            w_any;
   logic            w_accept;
   logic            w_lat_last;
   logic            w_rsp_done;
   logic [IW-1:0]   w_ptr_next;

   logic [1:0]      w_op_arr [NREQ];
   logic [W-1:0]    w_a_arr  [NREQ];
   logic [W-1:0]    w_b_arr  [NREQ];

   // Unpack the flat request buses so the winner can be selected by index.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_arr[gi] = req_op[2*gi +: 2];
      assign w_a_arr[gi]  = req_a[W*gi +: W];
      assign w_b_arr[gi]  = req_b[W*gi +: W];
   end

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_win_idx),
      .o_any   (w_any)
   );

   // Accept is gated by rst_n so nothing is handed off while reset is held.
   assign w_accept   = (r_state == IDLE) && rst_n && w_any;
   assign w_lat_last = (r_lat_cnt == CW'(LU_LAT - 1));
   assign w_rsp_done = (r_state == RESP) && rsp_ready[r_grant_idx];
   // The winner drops to lowest priority for the next arbitration.
   assign w_ptr_next = (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + IW'(1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept)   w_state_next = ISSUE;
         ISSUE:   if (w_lat_last) w_state_next = RESP;
         RESP:    if (w_rsp_done) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      lu_a      = '0;
      lu_b      = '0;
      lu_en     = '0;
      unique case (r_state)
         IDLE: begin
            if (rst_n) req_ready = w_grant;
         end
         ISSUE: begin
            lu_a  = r_a;
            lu_b  = r_b;
            lu_en = op2en(r_op);
         end
         RESP: begin
            rsp_valid = NREQ'(1) << r_grant_idx;
         end
         default: begin
         end
      endcase
   end

   assign rsp_data = r_rsp_data;

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_op        <= LU_OR;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_data  <= '0;
         r_lat_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_grant_idx <= w_win_idx;
            r_op        <= lu_op_e'(w_op_arr[w_win_idx]);
            r_a         <= w_a_arr[w_win_idx];
            r_b         <= w_b_arr[w_win_idx];
            r_rr_ptr    <= w_ptr_next;
            r_lat_cnt   <= '0;
         end
         if (r_state == ISSUE) begin
            r_lat_cnt <= r_lat_cnt + CW'(1);
            // Sample the combiner at the end of the last enable cycle.
            if (w_lat_last) r_rsp_data <= lu_out;
         end
      end
   end

`ifdef LU_ARB_PERF_EN
   // ---------------- Saturating grant counters ----------------
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_perf
      logic [15:0] r_cnt;
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_accept && w_grant[gi] && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
      assign grant_cnt[16*gi +: 16] = r_cnt;
   end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Self-checking bench for logic_unit_arbiter. A behavioural logic unit answers
// lu_en/lu_a/lu_b; a monitor pushes the expected result on every accept and
// pops/compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_logic_unit_arbiter;

   localparam int NREQ   = 4;
   localparam int W      = 8;
   localparam int LU_LAT = 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [2*NREQ-1:0]   req_op;
   logic [W*NREQ-1:0]   req_a;
   logic [W*NREQ-1:0]   req_b;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     rsp_valid;
   logic [W-1:0]        rsp_data;
   logic [NREQ-1:0]     rsp_ready;
   logic [W-1:0]        lu_a;
   logic [W-1:0]        lu_b;
   logic [3:0]          lu_en;
   logic [W-1:0]        lu_out;
`ifdef LU_ARB_PERF_EN
   logic [16*NREQ-1:0]  grant_cnt;
`endif

   always #5 clk = ~clk;

   logic_unit_arbiter #(
      .NREQ   (NREQ),
      .W      (W),
      .LU_LAT (LU_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .lu_a      (lu_a),
      .lu_b      (lu_b),
      .lu_en     (lu_en),
      .lu_out    (lu_out)
`ifdef LU_ARB_PERF_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   // Behavioural logic unit: four gated slices merged by a per-bit OR.
   always_comb begin
      lu_out = '0;
      if (lu_en[0]) lu_out = lu_out | (lu_a | lu_b);
      if (lu_en[1]) lu_out = lu_out | (lu_a ^ lu_b);
      if (lu_en[2]) lu_out = lu_out | ~(lu_a | lu_b);
      if (lu_en[3]) lu_out = lu_out | ~(lu_a ^ lu_b);
   end

   typedef struct {
      int           idx;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   gq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mon_idx;
   exp_t mon_e;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] lu_model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      case (op)
         2'd0:    return a | b;
         2'd1:    return a ^ b;
         2'd2:    return ~(a | b);
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Scoreboard monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_ready != '0) begin
            check_val("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
            mon_idx = oh2idx(req_ready);
            check_val("req_ready_has_valid", 32'(req_valid[mon_idx]), 32'd1);
            mon_e.idx  = mon_idx;
            mon_e.data = lu_model(req_op[2*mon_idx +: 2], req_a[W*mon_idx +: W],
                                  req_b[W*mon_idx +: W]);
            sb.push_back(mon_e);
            gq.push_back(mon_idx);
         end
         if (rsp_valid != '0) begin
            check_val("rsp_valid_onehot", 32'($onehot(rsp_valid)), 32'd1);
            if ((rsp_valid & rsp_ready) != '0) begin
               if (sb.size() == 0) begin
                  check_val("rsp_unexpected", 32'd1, 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check_val("rsp_route", 32'(oh2idx(rsp_valid)), 32'(mon_e.idx));
                  check_val("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                  $display("txn req%0d rsp_data=%02h expected=%02h", oh2idx(rsp_valid),
                           rsp_data, mon_e.data);
               end
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[i]      = 1'b1;
      req_op[2*i +: 2]  = op;
      req_a[W*i +: W]   = a;
      req_b[W*i +: W]   = b;
   endtask

   task automatic wait_accept(input int i);
      bit seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (req_ready[i]) seen = 1;
      end
      if (!seen) check_val("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && rsp_valid == '0) done = 1;
      end
      check_val("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_txn(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      @(posedge clk); #1;
      set_req(i, op, a, b);
      wait_accept(i);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      wait_drain();
   endtask

   logic [W-1:0] bp_exp;
   bit           bp_seen;

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;

      // 1: reset held for two edges
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_lu_en", 32'(lu_en), 32'd0);
      check_val("rst_lu_a", 32'(lu_a), 32'd0);
      check_val("rst_lu_b", 32'(lu_b), 32'd0);
      check_val("rst_rsp_data", 32'(rsp_data), 32'd0);
`ifdef LU_ARB_PERF_EN
      check_val("rst_grant_cnt", 32'(grant_cnt == '0), 32'd1);
`endif

      // 2: single XOR request from requester 0
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 2'd1, 8'hF0, 8'h3C);
      @(negedge clk);
      check_val("t2_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      check_val("t2_lu_en", 32'(lu_en), 32'h2);
      check_val("t2_lu_a", 32'(lu_a), 32'hF0);
      check_val("t2_lu_b", 32'(lu_b), 32'h3C);
      check_val("t2_issue_ready", 32'(req_ready), 32'd0);
      check_val("t2_issue_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check_val("t2_rsp_valid", 32'(rsp_valid), 32'h1);
      check_val("t2_rsp_data", 32'(rsp_data), 32'hCC);
      @(negedge clk);
      check_val("t2_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("t2_idle_lu_en", 32'(lu_en), 32'd0);

      // 3: all four requesting from rr_ptr=0
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      gq.delete();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 2'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (gq.size() >= 5) break;
      end
      req_valid = '0;
      check_val("t3_grant_count", 32'(gq.size()), 32'd5);
      for (int k = 0; k < 5; k++)
         if (k < gq.size()) check_val("t3_grant_order", 32'(gq[k]), 32'(k % NREQ));
      wait_drain();

      // 4: backpressure on requester 1, rsp_ready[2] must be ignored
      rsp_ready = 4'b0100;
      @(posedge clk); #1;
      set_req(1, 2'd2, 8'h55, 8'h0F);
      bp_exp = 8'hA0;
      wait_accept(1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      set_req(0, 2'd0, 8'h12, 8'h21);
      bp_seen = 0;
      for (int c = 0; c < 20 && !bp_seen; c++) begin
         @(negedge clk);
         if (rsp_valid[1]) bp_seen = 1;
      end
      check_val("t4_rsp_seen", 32'(bp_seen), 32'd1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         check_val("t4_hold_valid", 32'(rsp_valid), 32'h2);
         check_val("t4_hold_data", 32'(rsp_data), 32'(bp_exp));
         check_val("t4_hold_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = '1;
      wait_accept(0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_drain();

      // 5: reset during ISSUE drops the transaction
      @(posedge clk); #1;
      set_req(2, 2'd3, 8'hA5, 8'h5A);
      wait_accept(2);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(negedge clk);
      check_val("t5_issue_lu_en", 32'(lu_en), 32'h8);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("t5_rst_lu_en", 32'(lu_en), 32'd0);
      check_val("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("t5_rst_rsp_data", 32'(rsp_data), 32'd0);
      check_val("t5_rst_lu_a", 32'(lu_a), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      gq.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 8'(i), 8'h80);
      @(negedge clk);
      check_val("t5_ptr_zero", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      wait_drain();

`ifdef LU_ARB_PERF_EN
      // 6: grant counters and saturation
      for (int k = 0; k < 3; k++) do_txn(2, 2'd1, 8'(k), 8'h0F);
      check_val("t6_cnt2", 32'(grant_cnt[32 +: 16]), 32'd3);
      check_val("t6_cnt0", 32'(grant_cnt[0 +: 16]), 32'd1);
      @(negedge clk);
      force dut.g_perf[2].r_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.g_perf[2].r_cnt;
      do_txn(2, 2'd0, 8'h01, 8'h02);
      check_val("t6_cnt2_sat", 32'(grant_cnt[32 +: 16]), 32'hFFFF);
`else
      do_txn(3, 2'd3, 8'h3C, 8'h0F);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
